// File: rtl/imem_loader.sv
// Byte-stream program loader for the instruction memory.
// Holds the CPU in reset until the whole image is written.
module imem_loader #(
   parameter int ADDR_WIDTH = 8,
   parameter int RESET_HOLD = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_reset,
   output logic                  done,
   output logic                  err
);

   typedef enum logic [2:0] {
      S_HDR0,
      S_HDR1,
      S_DATA,
      S_HOLD,
      S_RUN,
      S_ERR
   } state_t;

   localparam logic [ADDR_WIDTH:0] WONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [31:0] DEPTH = 32'd1 << ADDR_WIDTH;

   state_t                  state_q, state_d;
   logic [15:0]             n_q, n_d;
   logic [ADDR_WIDTH:0]     widx_q, widx_d;
   logic [1:0]              bidx_q, bidx_d;
   logic [23:0]             asm_q, asm_d;
   logic [15:0]             hold_q, hold_d;
   logic                    we_q, we_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [31:0]             wdata_q, wdata_d;

   logic        accept;
   logic [15:0] n_full;

   assign accept = in_valid && in_ready;
   assign n_full = {n_q[15:8], in_data};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_HDR0;
         n_q     <= '0;
         widx_q  <= '0;
         bidx_q  <= '0;
         asm_q   <= '0;
         hold_q  <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         widx_q  <= widx_d;
         bidx_q  <= bidx_d;
         asm_q   <= asm_d;
         hold_q  <= hold_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      widx_d  = widx_q;
      bidx_d  = bidx_q;
      asm_d   = asm_q;
      hold_d  = hold_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         S_HDR0: begin
            if (accept) begin
               n_d[15:8] = in_data;
               state_d   = S_HDR1;
            end
         end
         S_HDR1: begin
            if (accept) begin
               n_d    = n_full;
               widx_d = '0;
               bidx_d = '0;
               hold_d = '0;
               if (n_full == 16'd0) begin
                  state_d = S_HOLD;
               end else if ({16'd0, n_full} > DEPTH) begin
                  state_d = S_ERR;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               asm_d  = {asm_q[15:0], in_data};
               bidx_d = bidx_q + 2'd1;
               if (bidx_q == 2'd3) begin
                  we_d    = 1'b1;
                  wdata_d = {asm_q, in_data};
                  addr_d  = widx_q[ADDR_WIDTH-1:0];
                  widx_d  = widx_q + WONE;
                  // widx_q is one bit wider than the address, so N = depth still matches
                  if (16'(widx_q) == n_q - 16'd1) begin
                     state_d = S_HOLD;
                     hold_d  = '0;
                  end
               end
            end
         end
         S_HOLD: begin
            if (hold_q == 16'(RESET_HOLD)) begin
               state_d = S_RUN;
            end else begin
               hold_d = hold_q + 16'd1;
            end
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      cpu_reset = 1'b1;
      done      = 1'b0;
      err       = 1'b0;
      unique case (state_q)
         S_HDR0, S_HDR1, S_DATA: in_ready = 1'b1;
         S_RUN: begin
            cpu_reset = 1'b0;
            done      = 1'b1;
         end
         S_ERR: err = 1'b1;
         default: begin
         end
      endcase
   end

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued
// as bytes are driven and matched when imem_we pulses.
module tb_imem_loader;

   localparam int AW = 8;
   localparam int RH = 3;

   typedef struct {
      logic [AW-1:0] a;
      logic [31:0]   d;
   } wr_t;

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_reset;
   logic          done;
   logic          err;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int last_we_cyc = 0;
   wr_t exp_q[$];
   int we_cycs[$];

   imem_loader #(.ADDR_WIDTH(AW), .RESET_HOLD(RH)) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .imem_we(imem_we),
      .imem_addr(imem_addr),
      .imem_wdata(imem_wdata),
      .cpu_reset(cpu_reset),
      .done(done),
      .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wr_t e;
         tests++;
         last_we_cyc = cyc;
         we_cycs.push_back(cyc);
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write addr=%h data=%h required none",
                     imem_addr, imem_wdata);
         end else begin
            e = exp_q.pop_front();
            if (imem_addr !== e.a || imem_wdata !== e.d) begin
               fails++;
               $display("FAIL write got %h@%h required %h@%h",
                        imem_wdata, imem_addr, e.d, e.a);
            end
         end
      end
   end

   task automatic do_reset();
      in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      we_cycs.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      logic rdy;
      int n;
      if (gap > 0) begin
         in_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
      in_data = b;
      in_valid = 1'b1;
      n = 0;
      forever begin
         rdy = in_ready;
         @(posedge clk);
         @(negedge clk);
         if (rdy) break;
         n++;
         if (n > 20) begin
            tests++;
            fails++;
            $display("FAIL byte_accept_timeout byte=%h got not ready required ready", b);
            break;
         end
      end
   endtask

   task automatic send_word(input logic [AW-1:0] a, input logic [31:0] w,
                            input int maxgap);
      wr_t e;
      e.a = a;
      e.d = w;
      exp_q.push_back(e);
      for (int k = 3; k >= 0; k--) begin
         send_byte(w[k*8 +: 8], maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
      end
   endtask

   task automatic send_header(input logic [15:0] n, input int maxgap);
      send_byte(n[15:8], maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
      send_byte(n[7:0], maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
   endtask

   task automatic wait_done(output int c);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      c = cyc;
      tests++;
      if (done !== 1'b1 || cpu_reset !== 1'b0) begin
         fails++;
         $display("FAIL done_timeout got done=%b cpu_reset=%b required 1 0",
                  done, cpu_reset);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      in_data = 8'h00;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      tests++;
      if ({in_ready, cpu_reset, imem_we, done, err} !== 5'b11000 ||
          imem_addr !== '0 || imem_wdata !== 32'h0) begin
         fails++;
         $display("FAIL reset_state got rdy/crst/we/done/err=%b addr=%h data=%h required 11000 0 0",
                  {in_ready, cpu_reset, imem_we, done, err}, imem_addr, imem_wdata);
      end
   endtask

   task automatic load_basic(input int maxgap);
      logic [31:0] w [3];
      w[0] = 32'h20080005;
      w[1] = 32'h20090007;
      w[2] = 32'h01095020;
      send_header(16'h0003, maxgap);
      for (int i = 0; i < 3; i++) send_word(AW'(i), w[i], maxgap);
      in_valid = 1'b0;
   endtask

   task automatic test_basic();
      int c;
      do_reset();
      load_basic(0);
      wait_done(c);
      tests++;
      if (c - last_we_cyc !== RH + 1) begin
         fails++;
         $display("FAIL basic_release got %0d required %0d", c - last_we_cyc, RH + 1);
      end
      tests++;
      if (we_cycs.size() != 3 || we_cycs[1] - we_cycs[0] != 4 ||
          we_cycs[2] - we_cycs[1] != 4) begin
         fails++;
         $display("FAIL basic_throughput got %0d writes required 3 spaced by 4",
                  we_cycs.size());
      end
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL basic_pending got %0d required 0", exp_q.size());
      end
   endtask

   task automatic test_post_done();
      int bad;
      bad = 0;
      in_data = 8'hA5;
      in_valid = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (in_ready !== 1'b0 || done !== 1'b1 || cpu_reset !== 1'b0) bad++;
      end
      in_valid = 1'b0;
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL post_done got %0d bad cycles required 0", bad);
      end
   endtask

   task automatic test_gaps();
      int c;
      do_reset();
      load_basic(5);
      wait_done(c);
      tests++;
      if (exp_q.size() != 0 || we_cycs.size() != 3) begin
         fails++;
         $display("FAIL gaps_writes got %0d writes required 3", we_cycs.size());
      end
   endtask

   task automatic test_n0();
      int t0;
      int c;
      do_reset();
      send_header(16'h0000, 0);
      in_valid = 1'b0;
      t0 = cyc;
      wait_done(c);
      tests++;
      if (c - t0 !== RH + 1 || we_cycs.size() != 0) begin
         fails++;
         $display("FAIL n0_release got %0d cycles %0d writes required %0d 0",
                  c - t0, we_cycs.size(), RH + 1);
      end
   endtask

   task automatic test_n256();
      int c;
      do_reset();
      send_header(16'd256, 0);
      for (int i = 0; i < 256; i++) send_word(AW'(i), $urandom, 0);
      in_valid = 1'b0;
      wait_done(c);
      tests++;
      if (we_cycs.size() != 256 || exp_q.size() != 0) begin
         fails++;
         $display("FAIL n256_writes got %0d required 256", we_cycs.size());
      end
   endtask

   task automatic test_n257();
      int bad;
      do_reset();
      send_header(16'd257, 0);
      tests++;
      if ({err, in_ready, cpu_reset, done} !== 4'b1010) begin
         fails++;
         $display("FAIL n257_state got err/rdy/crst/done=%b required 1010",
                  {err, in_ready, cpu_reset, done});
      end
      bad = 0;
      in_data = 8'h5A;
      in_valid = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if ({err, in_ready, cpu_reset} !== 3'b101) bad++;
      end
      in_valid = 1'b0;
      tests++;
      if (bad != 0 || we_cycs.size() != 0) begin
         fails++;
         $display("FAIL n257_hold got %0d bad %0d writes required 0 0",
                  bad, we_cycs.size());
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] w1;
      int c;
      do_reset();
      send_header(16'h0002, 0);
      send_word(AW'(0), 32'h11223344, 0);
      w1 = 32'h55667788;
      send_byte(w1[31:24], 0);
      send_byte(w1[23:16], 0);
      in_valid = 1'b0;
      tests++;
      if (exp_q.size() != 0 || we_cycs.size() != 1) begin
         fails++;
         $display("FAIL mid_word0 got %0d writes required 1", we_cycs.size());
      end
      do_reset();
      tests++;
      if ({in_ready, cpu_reset, imem_we, done} !== 4'b1100) begin
         fails++;
         $display("FAIL mid_reset got rdy/crst/we/done=%b required 1100",
                  {in_ready, cpu_reset, imem_we, done});
      end
      send_header(16'h0001, 0);
      send_word(AW'(0), 32'hDEADBEEF, 0);
      in_valid = 1'b0;
      wait_done(c);
      tests++;
      if (we_cycs.size() != 1 || exp_q.size() != 0) begin
         fails++;
         $display("FAIL mid_reload got %0d writes required 1", we_cycs.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_post_done();
      test_gaps();
      test_n0();
      test_n256();
      test_n257();
      test_reset_mid();
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Loads a program into the single-cycle MIPS instruction memory from a byte stream, then releases the CPU from reset. It sits between a host byte source (UART receiver, JTAG bridge or bench driver) and the instruction-memory write port. It drives the CPU's reset input, so a program can be loaded in hardware rather than preloaded from a hex file. It is the write-side counterpart of the data-memory dump path: the loader puts words in, and the dump path reads results out.

## Interface
- ADDR_WIDTH, 8: instruction-memory word-address width; depth = 2^ADDR_WIDTH words.
- RESET_HOLD, 3: cycles that cpu_reset stays high after the last word is written.

- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  loader can accept a byte this cycle.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_WIDTH  word address.
- imem_wdata  out  32  word to write.
- cpu_reset  out  1  reset to the CPU, active-high.
- done  out  1  load finished and the CPU is running.
- err  out  1  header word count exceeds memory depth.

## Operation
- Byte transfer: a byte is accepted on a posedge where in_valid && in_ready.
- Stream format:
  - 2-byte header giving word count N (16 bits, MSB first).
  - Then N words, 4 bytes each, MSB first (byte0 → wdata[31:24]).
- States:
  - HDR0: accept byte → N[15:8]; go to HDR1.
  - HDR1: accept byte → N[7:0].
    - If N == 0: go to HOLD.
    - If N > 2^ADDR_WIDTH: go to ERR.
    - Otherwise: go to DATA with word index = 0 and byte index = 0.
  - DATA: shift each accepted byte into a 32-bit assembly register.
    - On the 4th byte, register a write: imem_wdata = assembled word, imem_addr = word index, imem_we = 1 for exactly one cycle.
    - Then increment the word index and clear the byte index.
    - After word N−1 is accepted, go to HOLD.
  - HOLD: count RESET_HOLD cycles, counted from the cycle after entry; then go to RUN.
  - RUN: cpu_reset = 0, done = 1. Terminal until reset.
  - ERR: err = 1, cpu_reset = 1. Terminal until reset.
- in_ready = 1 only in HDR0, HDR1 and DATA. Bytes offered in HOLD, RUN or ERR are ignored and not consumed.
- Word index width is ADDR_WIDTH+1, so N = 2^ADDR_WIDTH is legal with no wrap. imem_addr takes the low ADDR_WIDTH bits.
- cpu_reset = 1 in every state except RUN.

## Timing
- Reset values:
  - State = HDR0.
  - in_ready = 1, cpu_reset = 1.
  - imem_we = 0, imem_addr = 0, imem_wdata = 0.
  - done = 0, err = 0.
  - Byte index = 0, word index = 0, N = 0.
- Write latency: imem_we is high in the cycle after the posedge that accepted a word's 4th byte.
- Throughput: one byte per cycle with no bubbles, including across word boundaries.
- in_valid gaps of any length are allowed; partial-word state is kept.
- Write/state overlap: the final word's imem_we pulse falls in the first HOLD cycle.
- Release: cpu_reset falls and done rises together, RESET_HOLD+1 cycles after the last-word imem_we cycle. The CPU's first fetch (PC = 0) is at the next posedge.
- Reset mid-load: returns all state to reset values in the next cycle, and any pending imem_we is cancelled. Words already written stay in the memory; the loader does not clear it.
- reset has priority over all transitions.

## Test plan
- Basic load:
  - Stimulus: header 0x0003, then words 0x20080005, 0x20090007, 0x01095020, no gaps.
  - Required: imem_we pulses at addr 0, 1, 2 with those words; cpu_reset falls 4 cycles after the third pulse; done = 1; PC starts at 0.
- Backpressure and gaps:
  - Stimulus: same stream with random in_valid gaps of 0–5 cycles.
  - Required: identical writes and ordering; no byte lost or duplicated.
- Boundaries:
  - N = 0: no imem_we; cpu_reset falls RESET_HOLD+1 cycles after the header's second byte.
  - N = 256 with ADDR_WIDTH = 8: last write at addr 0xFF, no wrap.
  - N = 257: err = 1, in_ready = 0, cpu_reset stays 1 and no writes occur.
- Reset mid-operation:
  - Stimulus: assert reset after 2 bytes of word 1, then send a fresh stream with N = 1, word 0xDEADBEEF.
  - Required: the only post-reset write is 0xDEADBEEF at addr 0; the earlier word 0 is untouched.
- Post-done traffic:
  - Stimulus: drive in_valid = 1 in RUN.
  - Required: in_ready = 0, no imem_we, done and cpu_reset stay unchanged.
